gclk_steady_checker: RTL and testbench

GCLK_STEADY_CHECKER -- requirements
Module: gclk_steady_checker

---
 rtl/gclk_steady_checker.sv | 110 +++++++++++
 tb/tb_gclk_steady_checker.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/gclk_steady_checker.sv
// Checks that sig holds steady between consecutive falling samples of a slow strobe,
// all sampled on the global clock; reports, counts and captures violations.
module gclk_steady_checker #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             strb,
  input  logic [WIDTH-1:0] sig,
  input  logic             clr,
  output logic             fell,
  output logic             rose,
  output logic             changed,
  output logic             armed,
  output logic             viol,
  output logic             err,
  output logic [CNT_W-1:0] viol_cnt,
  output logic [WIDTH-1:0] cap_sig,
  output logic [CNT_W-1:0] cap_pos
);

  typedef enum logic {IDLE, ARMED} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic             strb_q;
  logic [WIDTH-1:0] sig_q;
  logic [CNT_W-1:0] pos, pos_nxt;
  logic             cap_vld, cap_vld_nxt;
  logic             err_nxt;
  logic [CNT_W-1:0] viol_cnt_nxt, cap_pos_nxt;
  logic [WIDTH-1:0] cap_sig_nxt;
  logic             f, r, c, v;

  assign f = strb_q & ~strb;
  assign r = ~strb_q & strb;
  assign c = (sig != sig_q);
  // The falling sample itself opens a new window, so it is never checked.
  assign v = (state == ARMED) && !f && c;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    if (state == IDLE && f) state_nxt = ARMED;
  end

  // pos_nxt is the window position of the sample being taken now (fall sample = 0).
  always_comb begin
    pos_nxt = pos;
    if (f)                                      pos_nxt = '0;
    else if (state == ARMED && pos != CNT_MAX)  pos_nxt = pos + CNT_ONE;
  end

  // Clear is applied first, then a coincident violation is recorded on top of it.
  always_comb begin
    err_nxt      = clr ? 1'b0 : err;
    viol_cnt_nxt = clr ? '0   : viol_cnt;
    cap_vld_nxt  = clr ? 1'b0 : cap_vld;
    cap_sig_nxt  = clr ? '0   : cap_sig;
    cap_pos_nxt  = clr ? '0   : cap_pos;
    if (v) begin
      err_nxt = 1'b1;
      if (viol_cnt_nxt != CNT_MAX) viol_cnt_nxt = viol_cnt_nxt + CNT_ONE;
      if (!cap_vld_nxt) begin
        cap_vld_nxt = 1'b1;
        cap_sig_nxt = sig;
        cap_pos_nxt = pos_nxt;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      strb_q   <= 1'b0;
      sig_q    <= '0;
      pos      <= '0;
      cap_vld  <= 1'b0;
      fell     <= 1'b0;
      rose     <= 1'b0;
      changed  <= 1'b0;
      viol     <= 1'b0;
      err      <= 1'b0;
      viol_cnt <= '0;
      cap_sig  <= '0;
      cap_pos  <= '0;
    end else begin
      state    <= state_nxt;
      strb_q   <= strb;
      sig_q    <= sig;
      pos      <= pos_nxt;
      cap_vld  <= cap_vld_nxt;
      fell     <= f;
      rose     <= r;
      changed  <= c;
      viol     <= v;
      err      <= err_nxt;
      viol_cnt <= viol_cnt_nxt;
      cap_sig  <= cap_sig_nxt;
      cap_pos  <= cap_pos_nxt;
    end
  end

  assign armed = (state == ARMED);

endmodule

// File: tb/tb_gclk_steady_checker.sv
// Directed bench for gclk_steady_checker: default instance plus a CNT_W=2 instance
// on the same stimulus to exercise counter saturation.
module tb_gclk_steady_checker;

  logic       clk = 1'b0;
  logic       rst, strb, clr;
  logic [7:0] sig;

  logic        fell, rose, changed, armed, viol, err;
  logic [15:0] viol_cnt, cap_pos;
  logic [7:0]  cap_sig;

  logic        s_fell, s_rose, s_changed, s_armed, s_viol, s_err;
  logic [1:0]  s_viol_cnt, s_cap_pos;
  logic [7:0]  s_cap_sig;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  gclk_steady_checker #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .strb(strb), .sig(sig), .clr(clr),
    .fell(fell), .rose(rose), .changed(changed), .armed(armed), .viol(viol),
    .err(err), .viol_cnt(viol_cnt), .cap_sig(cap_sig), .cap_pos(cap_pos)
  );

  gclk_steady_checker #(.WIDTH(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .strb(strb), .sig(sig), .clr(clr),
    .fell(s_fell), .rose(s_rose), .changed(s_changed), .armed(s_armed), .viol(s_viol),
    .err(s_err), .viol_cnt(s_viol_cnt), .cap_sig(s_cap_sig), .cap_pos(s_cap_pos)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs are applied, then one edge is taken and outputs are read 1 ns later.
  task automatic step(input logic s, input logic [7:0] d);
    strb = s;
    sig  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_rec(input string tag, input logic e, input logic [31:0] n,
                           input logic [31:0] cs, input logic [31:0] cp);
    check({tag, ".err"},      err,      e);
    check({tag, ".viol_cnt"}, viol_cnt, n);
    check({tag, ".cap_sig"},  cap_sig,  cs);
    check({tag, ".cap_pos"},  cap_pos,  cp);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; strb = 1'b0; sig = 8'h00;
    step(0, 8'h00);
    step(0, 8'h00);
    check("rst.armed", armed, 0);
    check("rst.viol", viol, 0);
    check("rst.fell", fell, 0);
    check_rec("rst", 0, 0, 0, 0);
    rst = 1'b0;

    // First sample differs from reset sig_q while IDLE: no violation.
    step(1, 8'h5A);
    check("first.rose", rose, 1);
    check("first.changed", changed, 1);
    check("first.viol", viol, 0);
    step(1, 8'h5A);
    check("hold.rose", rose, 0);
    check("hold.changed", changed, 0);

    // Falling sample arms the checker.
    step(0, 8'h5A);
    check("fall.fell", fell, 1);
    check("fall.armed", armed, 1);
    check("fall.viol", viol, 0);
    check("fall.err", err, 0);
    step(0, 8'h5A);
    check("pos1.fell", fell, 0);
    step(0, 8'h5A);
    step(0, 8'h3C);
    check("v1.viol", viol, 1);
    check("v1.changed", changed, 1);
    check_rec("v1", 1, 1, 32'h3C, 3);
    step(0, 8'h3C);
    check("v1.pulse_end", viol, 0);
    check("v1.err_sticky", err, 1);

    // Change on the falling sample is excluded; the next change is not.
    step(1, 8'h3C);
    step(0, 8'h11);
    check("fallchg.fell", fell, 1);
    check("fallchg.changed", changed, 1);
    check("fallchg.viol", viol, 0);
    step(0, 8'h22);
    check("afterfall.viol", viol, 1);
    check_rec("afterfall", 1, 2, 32'h3C, 3);

    // clr alone.
    clr = 1'b1;
    step(0, 8'h22);
    clr = 1'b0;
    check("clr.armed", armed, 1);
    check_rec("clr", 0, 0, 0, 0);
    check("clr.sat_cnt", s_viol_cnt, 0);

    // Back-to-back violations; saturation in the narrow instance.
    step(0, 8'h33); check("b2b0.viol", viol, 1);
    step(0, 8'h44); check("b2b1.viol", viol, 1);
    step(0, 8'h55); check("b2b2.viol", viol, 1);
    step(0, 8'h66); check("b2b3.viol", viol, 1);
    check_rec("b2b", 1, 4, 32'h33, 3);
    check("b2b.sat_cnt4", s_viol_cnt, 3);
    step(0, 8'h77);
    check("b2b.cnt5", viol_cnt, 5);
    check("b2b.sat_cnt5", s_viol_cnt, 3);
    check("b2b.sat_viol", s_viol, 1);

    // clr coinciding with a violation, then clr alone.
    clr = 1'b1;
    step(0, 8'h88);
    check("clrv.viol", viol, 1);
    check_rec("clrv", 1, 1, 32'h88, 8);
    check("clrv.sat_cnt", s_viol_cnt, 1);
    step(0, 8'h88);
    clr = 1'b0;
    check_rec("clr2", 0, 0, 0, 0);
    check("clr2.armed", armed, 1);

    // Reset mid-window, then toggling with strb high must not be checked.
    step(1, 8'h88);
    rst = 1'b1;
    step(1, 8'h88);
    rst = 1'b0;
    check("rstmid.armed", armed, 0);
    check("rstmid.viol", viol, 0);
    step(1, 8'h01); check("idle0.viol", viol, 0);
    step(1, 8'h02); check("idle1.viol", viol, 0);
    step(1, 8'h03); check("idle2.viol", viol, 0);
    check("idle.armed", armed, 0);
    check("idle.err", err, 0);
    step(0, 8'h03);
    check("rearm.fell", fell, 1);
    check("rearm.armed", armed, 1);
    check("rearm.viol", viol, 0);
    step(0, 8'h04);
    check("resume.viol", viol, 1);
    check_rec("resume", 1, 1, 32'h04, 1);
    step(0, 8'h04);
    check("resume.pulse_end", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
